rrf_free_list: RTL

//  Free-tag allocator for the 128-entry rename register file (RRF). Replaces the priority scan over busy bits.

---
 rtl/rename_pkg.sv | 11 +
 rtl/rrf_free_list.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types used by the RRF free-tag allocator.
package rename_pkg;

    localparam int unsigned NUM_TAGS    = 128;
    localparam int unsigned TAG_W       = 7;
    localparam int unsigned ALLOC_PORTS = 2;
    localparam int unsigned FREE_PORTS  = 2;

    typedef logic [TAG_W-1:0] rrf_tag_t;

endpackage

// File: rtl/rrf_free_list.sv
// Circular FIFO of free RRF tags: decode pops up to two tags per cycle, ROB retire pushes up to two.
// A free bitmap rejects double frees so the FIFO can never overflow.
module rrf_free_list #(
    parameter int unsigned NUM_TAGS = rename_pkg::NUM_TAGS,
    parameter int unsigned TAG_W    = rename_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             alloc_req0,
    input  logic             alloc_req1,
    output logic [TAG_W-1:0] alloc_tag0,
    output logic [TAG_W-1:0] alloc_tag1,
    output logic             two_available,
    input  logic             free_en0,
    input  logic [TAG_W-1:0] free_tag0,
    input  logic             free_en1,
    input  logic [TAG_W-1:0] free_tag1,
    output logic [TAG_W:0]   free_count,
    output logic             err_underflow,
    output logic             err_double
);

    localparam int unsigned FP = rename_pkg::FREE_PORTS;

    logic [TAG_W-1:0] fifo_q [NUM_TAGS];
    logic [TAG_W-1:0] fifo_d [NUM_TAGS];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [NUM_TAGS-1:0] is_free_q, is_free_d;
    logic             err_underflow_q, err_underflow_d;
    logic             err_double_q, err_double_d;

    logic             free_en  [FP];
    logic [TAG_W-1:0] free_tag [FP];
    logic [TAG_W-1:0] head_p1;

    assign free_en[0]  = free_en0;
    assign free_en[1]  = free_en1;
    assign free_tag[0] = free_tag0;
    assign free_tag[1] = free_tag1;

    assign head_p1       = head_q + TAG_W'(1);
    assign alloc_tag0    = fifo_q[head_q];
    assign alloc_tag1    = fifo_q[head_p1];
    assign two_available = (count_q >= (TAG_W+1)'(2));
    assign free_count    = count_q;
    assign err_underflow = err_underflow_q;
    assign err_double    = err_double_q;

    always_comb begin : next_state
        logic [1:0]    pop_cnt;
        logic [1:0]    push_cnt;
        logic [FP-1:0] acc;
        logic          dup;

        fifo_d          = fifo_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        is_free_d       = is_free_q;
        err_underflow_d = err_underflow_q;
        err_double_d    = err_double_q;
        pop_cnt         = '0;
        push_cnt        = '0;
        acc             = '0;
        dup             = 1'b0;

        if (!stall) begin
            if (flush) begin
                for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                    fifo_d[i] = TAG_W'(i);
                end
                head_d    = '0;
                tail_d    = '0;
                count_d   = (TAG_W+1)'(NUM_TAGS);
                is_free_d = '1;
            end else begin
                if (alloc_req0 || alloc_req1) begin
                    if (!alloc_req0 || !two_available) begin
                        err_underflow_d = 1'b1;
                    end else begin
                        pop_cnt = alloc_req1 ? 2'd2 : 2'd1;
                        is_free_d[fifo_q[head_q]] = 1'b0;
                        if (alloc_req1) begin
                            is_free_d[fifo_q[head_p1]] = 1'b0;
                        end
                    end
                end

                // Legality is judged on the pre-cycle bitmap; a repeat of an earlier port's tag is a double free.
                for (int unsigned p = 0; p < FP; p++) begin
                    dup = 1'b0;
                    for (int unsigned k = 0; k < p; k++) begin
                        if (acc[k] && (free_tag[k] == free_tag[p])) begin
                            dup = 1'b1;
                        end
                    end
                    if (free_en[p]) begin
                        if (is_free_q[free_tag[p]] || dup) begin
                            err_double_d = 1'b1;
                        end else begin
                            acc[p] = 1'b1;
                            fifo_d[tail_q + TAG_W'(push_cnt)] = free_tag[p];
                            is_free_d[free_tag[p]] = 1'b1;
                            push_cnt = push_cnt + 2'd1;
                        end
                    end
                end

                head_d  = head_q + TAG_W'(pop_cnt);
                tail_d  = tail_q + TAG_W'(push_cnt);
                count_d = count_q - (TAG_W+1)'(pop_cnt) + (TAG_W+1)'(push_cnt);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                fifo_q[i] <= TAG_W'(i);
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= (TAG_W+1)'(NUM_TAGS);
            is_free_q       <= '1;
            err_underflow_q <= 1'b0;
            err_double_q    <= 1'b0;
        end else begin
            fifo_q          <= fifo_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            is_free_q       <= is_free_d;
            err_underflow_q <= err_underflow_d;
            err_double_q    <= err_double_d;
        end
    end

endmodule
